// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: forwarding select codes,
// controller states and bubble counts per producer stage.
package pipeline_hazard_ctrl_pkg;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_EXMEM   = 2'b01;
    localparam logic [1:0] FWD_WB      = 2'b10;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_e;

    // Bubbles needed before an ID reader can see the producer's value.
    localparam int unsigned BUB_FWD_LOAD  = 1;
    localparam int unsigned BUB_WB        = 1;
    localparam int unsigned BUB_NOFWD_MEM = 2;
    localparam int unsigned BUB_NOFWD_EX  = 3;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// EX-stage operand forwarding select: compares ID/EX sources with the EX/MEM
// and MEM/WB destinations; the EX/MEM match wins.
module hazard_fwd_select
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] ex_rs_i,
    input  logic [REG_AW-1:0] ex_rt_i,
    input  logic [REG_AW-1:0] mem_wreg_i,
    input  logic              mem_regwrite_i,
    input  logic [REG_AW-1:0] wb_wreg_i,
    input  logic              wb_regwrite_i,
    output logic [1:0]        fwd_a_sel_o,
    output logic [1:0]        fwd_b_sel_o
);

    logic mem_valid;
    logic wb_valid;

    // A load never sits in EX/MEM while its consumer is in EX: the load-use
    // bubble guarantees it, so no load qualifier is needed here.
    assign mem_valid = mem_regwrite_i && (mem_wreg_i != '0);
    assign wb_valid  = wb_regwrite_i  && (wb_wreg_i  != '0);

    always_comb begin
        fwd_a_sel_o = FWD_REGFILE;
        fwd_b_sel_o = FWD_REGFILE;
        if (mem_valid && (mem_wreg_i == ex_rs_i)) begin
            fwd_a_sel_o = FWD_EXMEM;
        end else if (wb_valid && (wb_wreg_i == ex_rs_i)) begin
            fwd_a_sel_o = FWD_WB;
        end
        if (mem_valid && (mem_wreg_i == ex_rt_i)) begin
            fwd_b_sel_o = FWD_EXMEM;
        end else if (wb_valid && (wb_wreg_i == ex_rt_i)) begin
            fwd_b_sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: RAW stall counting,
// redirect flushes and EX forwarding selects. Define HAZARD_FWD_EN for forwarding mode.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_uses_rs_i,
    input  logic              id_uses_rt_i,
    input  logic [REG_AW-1:0] ex_rs_i,
    input  logic [REG_AW-1:0] ex_rt_i,
    input  logic [REG_AW-1:0] ex_wreg_i,
    input  logic              ex_regwrite_i,
    input  logic              ex_memread_i,
    input  logic [REG_AW-1:0] mem_wreg_i,
    input  logic              mem_regwrite_i,
    input  logic [REG_AW-1:0] wb_wreg_i,
    input  logic              wb_regwrite_i,
    input  logic              redirect_mem_i,
    output logic              pc_enable_o,
    output logic              if_id_enable_o,
    output logic              if_id_flush_o,
    output logic              id_ex_flush_o,
    output logic              ex_mem_flush_o,
    output logic [1:0]        fwd_a_sel_o,
    output logic [1:0]        fwd_b_sel_o,
    output logic              stalled_o
);

    function automatic logic src_hit(input logic [REG_AW-1:0] src,
                                     input logic              use_src,
                                     input logic [REG_AW-1:0] dst,
                                     input logic              wr);
        return use_src && wr && (dst != '0) && (src == dst);
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] bub_n;
    logic             ex_hit;
    logic             wb_hit;
    logic [1:0]       sel_a, sel_b;

    assign ex_hit = src_hit(id_rs_i, id_uses_rs_i, ex_wreg_i, ex_regwrite_i)
                  | src_hit(id_rt_i, id_uses_rt_i, ex_wreg_i, ex_regwrite_i);
    assign wb_hit = src_hit(id_rs_i, id_uses_rs_i, wb_wreg_i, wb_regwrite_i)
                  | src_hit(id_rt_i, id_uses_rt_i, wb_wreg_i, wb_regwrite_i);

    hazard_fwd_select #(
        .REG_AW(REG_AW)
    ) u_fwd (
        .ex_rs_i       (ex_rs_i),
        .ex_rt_i       (ex_rt_i),
        .mem_wreg_i    (mem_wreg_i),
        .mem_regwrite_i(mem_regwrite_i),
        .wb_wreg_i     (wb_wreg_i),
        .wb_regwrite_i (wb_regwrite_i),
        .fwd_a_sel_o   (sel_a),
        .fwd_b_sel_o   (sel_b)
    );

`ifdef HAZARD_FWD_EN
    always_comb begin
        bub_n = '0;
        if (wb_hit)                  bub_n = CNT_W'(BUB_WB);
        if (ex_hit && ex_memread_i)  bub_n = CNT_W'(BUB_FWD_LOAD);
    end

    assign fwd_a_sel_o = reset ? sel_a : FWD_REGFILE;
    assign fwd_b_sel_o = reset ? sel_b : FWD_REGFILE;
`else
    logic mem_hit;
    logic unused_fwd;

    assign mem_hit = src_hit(id_rs_i, id_uses_rs_i, mem_wreg_i, mem_regwrite_i)
                   | src_hit(id_rt_i, id_uses_rt_i, mem_wreg_i, mem_regwrite_i);

    always_comb begin
        bub_n = '0;
        if (ex_hit)       bub_n = CNT_W'(BUB_NOFWD_EX);
        else if (mem_hit) bub_n = CNT_W'(BUB_NOFWD_MEM);
        else if (wb_hit)  bub_n = CNT_W'(BUB_WB);
    end

    assign unused_fwd  = ^{sel_a, sel_b, ex_memread_i};
    assign fwd_a_sel_o = FWD_REGFILE;
    assign fwd_b_sel_o = FWD_REGFILE;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pc_enable_o    = 1'b1;
        if_id_enable_o = 1'b1;
        if_id_flush_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        ex_mem_flush_o = 1'b0;
        stalled_o      = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (bub_n != '0) begin
                    pc_enable_o    = 1'b0;
                    if_id_enable_o = 1'b0;
                    id_ex_flush_o  = 1'b1;
                    stalled_o      = 1'b1;
                    cnt_d          = bub_n - CNT_W'(1);
                    state_d        = (bub_n > CNT_W'(1)) ? ST_STALL : ST_RUN;
                end
            end
            ST_STALL: begin
                // Worst case is already loaded, so no re-detection while stalling.
                pc_enable_o    = 1'b0;
                if_id_enable_o = 1'b0;
                id_ex_flush_o  = 1'b1;
                stalled_o      = 1'b1;
                cnt_d          = cnt_q - CNT_W'(1);
                state_d        = (cnt_q == CNT_W'(1)) ? ST_RUN : ST_STALL;
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase

        if (redirect_mem_i) begin
            pc_enable_o    = 1'b1;
            if_id_enable_o = 1'b1;
            if_id_flush_o  = 1'b1;
            id_ex_flush_o  = 1'b1;
            ex_mem_flush_o = 1'b1;
            cnt_d          = '0;
            state_d        = ST_RUN;
        end

        if (!reset) begin
            pc_enable_o    = 1'b0;
            if_id_enable_o = 1'b0;
            if_id_flush_o  = 1'b1;
            id_ex_flush_o  = 1'b1;
            ex_mem_flush_o = 1'b1;
            stalled_o      = 1'b0;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl; expectations follow HAZARD_FWD_EN
// in the same way as the design build.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_wreg, mem_wreg, wb_wreg;
    logic       id_uses_rs, id_uses_rt, ex_regwrite, ex_memread;
    logic       mem_regwrite, wb_regwrite, redirect_mem;
    logic       pc_enable, if_id_enable, if_id_flush, id_ex_flush, ex_mem_flush, stalled;
    logic [1:0] fwd_a_sel, fwd_b_sel;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .REG_AW(5),
        .CNT_W (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .id_rs_i       (id_rs),
        .id_rt_i       (id_rt),
        .id_uses_rs_i  (id_uses_rs),
        .id_uses_rt_i  (id_uses_rt),
        .ex_rs_i       (ex_rs),
        .ex_rt_i       (ex_rt),
        .ex_wreg_i     (ex_wreg),
        .ex_regwrite_i (ex_regwrite),
        .ex_memread_i  (ex_memread),
        .mem_wreg_i    (mem_wreg),
        .mem_regwrite_i(mem_regwrite),
        .wb_wreg_i     (wb_wreg),
        .wb_regwrite_i (wb_regwrite),
        .redirect_mem_i(redirect_mem),
        .pc_enable_o   (pc_enable),
        .if_id_enable_o(if_id_enable),
        .if_id_flush_o (if_id_flush),
        .id_ex_flush_o (id_ex_flush),
        .ex_mem_flush_o(ex_mem_flush),
        .fwd_a_sel_o   (fwd_a_sel),
        .fwd_b_sel_o   (fwd_b_sel),
        .stalled_o     (stalled)
    );

    typedef struct {
        logic       rst;
        logic [4:0] rs;
        logic       ur;
        logic [4:0] rt;
        logic       ut;
        logic [4:0] exrs, exrt, exw;
        logic       exrw, exmr;
        logic [4:0] memw;
        logic       memrw;
        logic [4:0] wbw;
        logic       wbrw;
        logic       redir;
    } in_t;

    typedef struct {
        string      name;
        logic [9:0] exp;
    } exp_t;

    exp_t        sbq[$];
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Packed order: pc_en, if_id_en, if_id_fl, id_ex_fl, ex_mem_fl, fwd_a, fwd_b, stalled
    localparam logic [9:0] E_RST = {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0};

    function automatic logic [9:0] e_run(input logic [1:0] fa, input logic [1:0] fb);
        return {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, fa, fb, 1'b0};
    endfunction

    function automatic logic [9:0] e_stall();
        return {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1};
    endfunction

    function automatic logic [9:0] e_redir(input logic st);
        return {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, st};
    endfunction

    function automatic in_t idle();
        in_t v;
        v.rst = 1'b1; v.rs = '0; v.ur = 1'b0; v.rt = '0; v.ut = 1'b0;
        v.exrs = '0; v.exrt = '0; v.exw = '0; v.exrw = 1'b0; v.exmr = 1'b0;
        v.memw = '0; v.memrw = 1'b0; v.wbw = '0; v.wbrw = 1'b0; v.redir = 1'b0;
        return v;
    endfunction

    task automatic step(input string name, input in_t v, input logic [9:0] e);
        exp_t s;
        @(posedge clk);
        #1;
        reset = v.rst;       id_rs = v.rs;         id_uses_rs = v.ur;
        id_rt = v.rt;        id_uses_rt = v.ut;    ex_rs = v.exrs;
        ex_rt = v.exrt;      ex_wreg = v.exw;      ex_regwrite = v.exrw;
        ex_memread = v.exmr; mem_wreg = v.memw;    mem_regwrite = v.memrw;
        wb_wreg = v.wbw;     wb_regwrite = v.wbrw; redirect_mem = v.redir;
        s.name = name;
        s.exp  = e;
        sbq.push_back(s);
    endtask

    initial begin : monitor
        exp_t       s;
        logic [9:0] act;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                s   = sbq.pop_front();
                act = {pc_enable, if_id_enable, if_id_flush, id_ex_flush, ex_mem_flush,
                       fwd_a_sel, fwd_b_sel, stalled};
                n_tests++;
                if (act !== s.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %b expected %b (pc,ifid_en,ifid_fl,idex_fl,exmem_fl,fa,fb,stalled)",
                             s.name, act, s.exp);
                end
            end
        end
    end

    initial begin : stimulus
        in_t v;
        reset = 1'b0;
        id_rs = '0; id_rt = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        ex_rs = '0; ex_rt = '0; ex_wreg = '0; ex_regwrite = 1'b0; ex_memread = 1'b0;
        mem_wreg = '0; mem_regwrite = 1'b0; wb_wreg = '0; wb_regwrite = 1'b0;
        redirect_mem = 1'b0;

        v = idle(); v.rst = 1'b0;
        step("reset_a", v, E_RST);
        step("reset_b", v, E_RST);
        step("idle_run", idle(), e_run(2'b00, 2'b00));

        v = idle(); v.rs = 5'd0; v.ur = 1'b1; v.exw = 5'd0; v.exrw = 1'b1; v.exmr = 1'b1;
        step("zero_reg_no_stall", v, e_run(2'b00, 2'b00));
        v = idle(); v.rt = 5'd7; v.ut = 1'b0; v.exw = 5'd7; v.exrw = 1'b1; v.exmr = 1'b1;
        step("rt_unused_no_stall", v, e_run(2'b00, 2'b00));
        v = idle(); v.rs = 5'd7; v.ur = 1'b1; v.exw = 5'd7; v.exrw = 1'b0; v.exmr = 1'b1;
        step("no_regwrite_no_stall", v, e_run(2'b00, 2'b00));

        v = idle(); v.rt = 5'd9; v.ut = 1'b1; v.wbw = 5'd9; v.wbrw = 1'b1;
        step("wb_hit_stall", v, e_stall());
        step("wb_hit_done", idle(), e_run(2'b00, 2'b00));

        v = idle(); v.rs = 5'd8; v.ur = 1'b1; v.exw = 5'd8; v.exrw = 1'b1; v.exmr = 1'b1; v.redir = 1'b1;
        step("redirect_over_detect", v, e_redir(1'b1));
        step("redirect_no_load", idle(), e_run(2'b00, 2'b00));

`ifdef HAZARD_FWD_EN
        v = idle(); v.rs = 5'd8; v.ur = 1'b1; v.exw = 5'd8; v.exrw = 1'b1; v.exmr = 1'b1;
        step("lw_use_stall", v, e_stall());
        v = idle(); v.rs = 5'd8; v.ur = 1'b1; v.memw = 5'd8; v.memrw = 1'b1;
        step("lw_in_mem_no_stall", v, e_run(2'b00, 2'b00));
        v = idle(); v.exrs = 5'd8; v.wbw = 5'd8; v.wbrw = 1'b1;
        step("lw_fwd_a_wb", v, e_run(2'b10, 2'b00));
        v = idle(); v.exrt = 5'd8; v.memw = 5'd8; v.memrw = 1'b1;
        step("fwd_b_exmem", v, e_run(2'b00, 2'b01));
        v = idle(); v.exrt = 5'd8; v.wbw = 5'd8; v.wbrw = 1'b1;
        step("fwd_b_wb", v, e_run(2'b00, 2'b10));
        v = idle(); v.exrs = 5'd8; v.memw = 5'd8; v.memrw = 1'b1; v.wbw = 5'd8; v.wbrw = 1'b1;
        step("fwd_mem_priority", v, e_run(2'b01, 2'b00));
        v = idle(); v.exrs = 5'd0; v.exrt = 5'd0; v.memw = 5'd0; v.memrw = 1'b1;
        step("fwd_zero_reg", v, e_run(2'b00, 2'b00));
        v = idle(); v.rs = 5'd8; v.ur = 1'b1; v.exw = 5'd8; v.exrw = 1'b1;
        step("alu_in_ex_no_stall", v, e_run(2'b00, 2'b00));
`else
        v = idle(); v.rs = 5'd8; v.ur = 1'b1; v.exw = 5'd8; v.exrw = 1'b1;
        step("ex_hit_cyc1", v, e_stall());
        v = idle(); v.rs = 5'd8; v.ur = 1'b1; v.memw = 5'd8; v.memrw = 1'b1;
        step("ex_hit_cyc2", v, e_stall());
        v = idle(); v.rs = 5'd8; v.ur = 1'b1; v.wbw = 5'd8; v.wbrw = 1'b1;
        step("ex_hit_cyc3", v, e_stall());
        v = idle(); v.exrs = 5'd8; v.exrt = 5'd8; v.memw = 5'd8; v.memrw = 1'b1; v.wbw = 5'd8; v.wbrw = 1'b1;
        step("ex_hit_done_fwd_tied", v, e_run(2'b00, 2'b00));

        v = idle(); v.rt = 5'd5; v.ut = 1'b1; v.memw = 5'd5; v.memrw = 1'b1;
        step("mem_hit_cyc1", v, e_stall());
        step("mem_hit_cyc2", idle(), e_stall());
        step("mem_hit_done", idle(), e_run(2'b00, 2'b00));

        v = idle(); v.rs = 5'd8; v.ur = 1'b1; v.exw = 5'd8; v.exrw = 1'b1;
        step("redir_stall_cyc1", v, e_stall());
        v.redir = 1'b1;
        step("redir_in_stall", v, e_redir(1'b1));
        step("redir_cnt_cleared", idle(), e_run(2'b00, 2'b00));
`endif

        v = idle(); v.rs = 5'd8; v.ur = 1'b1; v.exw = 5'd8; v.exrw = 1'b1; v.exmr = 1'b1;
        step("pre_reset_stall", v, e_stall());
        v.rst = 1'b0;
        step("reset_mid_stall", v, E_RST);
        step("reset_hold", v, E_RST);
        step("reset_release_run", idle(), e_run(2'b00, 2'b00));
        step("reset_release_run2", idle(), e_run(2'b00, 2'b00));

        for (int i = 0; i < 8 && sbq.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        if (sbq.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d pending expectations, required 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
